// File: rtl/result_ser_pkg.sv
// result_ser_pkg: shared types and default sizes for the result serializer.
// Optional feature macro used by the files importing this package: RESULT_SER_CHECKSUM_EN.
package result_ser_pkg;

  localparam int RES_IN_W   = 3072;
  localparam int RES_OUT_W  = 32;
  localparam int RES_NWORDS = RES_IN_W / RES_OUT_W;
  localparam int IDX_W      = $clog2(RES_NWORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CHK  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/result_xor_acc.sv
// result_xor_acc: running XOR of the words streamed out of one frame.
// Used by result_serializer only when RESULT_SER_CHECKSUM_EN is defined.
module result_xor_acc
  import result_ser_pkg::*;
#(
  parameter int W = RES_OUT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] r_acc;

  // Clear starts a new frame's checksum; clear wins over a simultaneous enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/result_serializer.sv
// result_serializer: captures a wide hash result on fifo_write and streams it
// out LSW first as OUT_W-bit words over valid/ready, with frame counting and
// sticky overflow on dropped strobes.
// Optional feature macro: RESULT_SER_CHECKSUM_EN (adds a trailing XOR checksum beat).
module result_serializer
  import result_ser_pkg::*;
#(
  parameter int IN_W  = RES_IN_W,
  parameter int OUT_W = RES_OUT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [IN_W-1:0]  result,
  input  logic             fifo_write,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overflow,
  output logic [15:0]      frame_cnt
);

  localparam int NWORDS  = IN_W / OUT_W;
  localparam int L_IDX_W = $clog2(NWORDS + 1);
  localparam logic [L_IDX_W-1:0] LAST_IDX = L_IDX_W'(NWORDS - 1);

  ser_state_t         r_state;
  ser_state_t         w_nextState;
  logic [IN_W-1:0]    r_buf;
  logic [L_IDX_W-1:0] r_idx;
  logic               r_overflow;
  logic [15:0]        r_frameCnt;

  logic [OUT_W-1:0]   w_word;
  logic               w_valid;
  logic               w_isLastWord;
  logic               w_hs;
  logic               w_sendHs;
  logic               w_finalHs;
  logic               w_capture;
  logic               w_drop;

  assign w_word       = r_buf[r_idx*OUT_W +: OUT_W];
  assign w_valid      = (r_state != ST_IDLE);
  assign w_isLastWord = (r_idx == LAST_IDX);
  assign w_hs         = w_valid & out_ready;
  assign w_sendHs     = w_hs && (r_state == ST_SEND);

`ifdef RESULT_SER_CHECKSUM_EN
  logic [OUT_W-1:0] w_acc;

  assign w_finalHs = w_hs && (r_state == ST_CHK);

  result_xor_acc #(
    .W(OUT_W)
  ) u_xor_acc (
    .i_clk  (clk_in),
    .i_rst  (rst),
    .i_clear(w_capture),
    .i_en   (w_sendHs),
    .i_data (w_word),
    .o_acc  (w_acc)
  );
`else
  assign w_finalHs = w_sendHs && w_isLastWord;
`endif

  // A strobe is taken when idle or on the frame's final handshake; otherwise it is lost.
  assign w_capture = fifo_write && ((r_state == ST_IDLE) || w_finalHs);
  assign w_drop    = fifo_write && !w_capture;

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and beat outputs; the final beat re-enters SEND directly on a back-to-back strobe.
  always_comb begin
    w_nextState = r_state;
    out_data    = '0;
    out_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fifo_write) begin
          w_nextState = ST_SEND;
        end
      end
      ST_SEND: begin
        out_data = w_word;
`ifdef RESULT_SER_CHECKSUM_EN
        if (out_ready && w_isLastWord) begin
          w_nextState = ST_CHK;
        end
`else
        out_last = w_isLastWord;
        if (out_ready && w_isLastWord) begin
          w_nextState = fifo_write ? ST_SEND : ST_IDLE;
        end
`endif
      end
`ifdef RESULT_SER_CHECKSUM_EN
      ST_CHK: begin
        out_data = w_acc;
        out_last = 1'b1;
        if (out_ready) begin
          w_nextState = fifo_write ? ST_SEND : ST_IDLE;
        end
      end
`endif
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Capture buffer, word index, sticky overflow and completed-frame counter.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_buf      <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
      r_frameCnt <= '0;
    end else begin
      if (w_capture) begin
        r_buf <= result;
        r_idx <= '0;
      end else if (w_sendHs) begin
        r_idx <= w_isLastWord ? '0 : r_idx + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_finalHs) begin
        r_frameCnt <= r_frameCnt + 16'd1;
      end
    end
  end

  assign out_valid = w_valid;
  assign busy      = w_valid;
  assign overflow  = r_overflow;
  assign frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: scenario table, hand-written corner sequences and a
// randomized run against a queue-based frame model.
// Honors RESULT_SER_CHECKSUM_EN (expects the extra checksum beat when defined).
module tb_result_serializer;
  import result_ser_pkg::*;

  localparam int IN_W   = RES_IN_W;
  localparam int OUT_W  = RES_OUT_W;
  localparam int NWORDS = IN_W / OUT_W;
`ifdef RESULT_SER_CHECKSUM_EN
  localparam int BEATS = NWORDS + 1;
`else
  localparam int BEATS = NWORDS;
`endif

  logic             clk_in = 1'b0;
  logic             rst = 1'b0;
  logic [IN_W-1:0]  result = '0;
  logic             fifo_write = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             busy;
  logic             overflow;
  logic [15:0]      frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } beat_t;

  beat_t       expQ[$];
  logic        modelOvf;
  logic [15:0] modelFrames;
  int          cycleNo;

  typedef struct {
    string       name;
    int          pattern;
    int          readyMode;
    int          strobe2At;
    logic [15:0] expFrames;
    logic        expOvf;
  } scen_t;

  scen_t scens[5];

  result_serializer dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .result    (result),
    .fifo_write(fifo_write),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", name, cycleNo, actual, expected);
    end
  endtask

  function automatic logic [IN_W-1:0] makePattern(input int kind);
    logic [IN_W-1:0] v;
    v = '0;
    for (int i = 0; i < NWORDS; i++) begin
      case (kind)
        0:       v[i*OUT_W +: OUT_W] = 32'(i);
        1:       v[i*OUT_W +: OUT_W] = (i == 5) ? 32'hA5A5_A5A5 : 32'h0;
        2:       v[i*OUT_W +: OUT_W] = 32'hFFFF_FFFF;
        default: v[i*OUT_W +: OUT_W] = $urandom;
      endcase
    end
    return v;
  endfunction

  // A frame is all words LSW first, then (with the checksum option) their XOR.
  task automatic pushFrame(input logic [IN_W-1:0] res);
    beat_t       b;
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < NWORDS; i++) begin
      b.word = res[i*OUT_W +: OUT_W];
      b.last = (i == BEATS - 1);
      x      = x ^ b.word;
      expQ.push_back(b);
    end
`ifdef RESULT_SER_CHECKSUM_EN
    b.word = x;
    b.last = 1'b1;
    expQ.push_back(b);
`endif
  endtask

  // Drive one cycle, compare visible outputs with the model, advance model and clock.
  task automatic applyStimulus(input logic fw, input logic [IN_W-1:0] res, input logic rdy);
    beat_t b;
    fifo_write = fw;
    result     = res;
    out_ready  = rdy;
    checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() > 0));
    checkOutput("busy", 32'(busy), 32'(expQ.size() > 0));
    checkOutput("overflow", 32'(overflow), 32'(modelOvf));
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(modelFrames));
    if (expQ.size() > 0) begin
      checkOutput("out_data", out_data, expQ[0].word);
      checkOutput("out_last", 32'(out_last), 32'(expQ[0].last));
    end else begin
      checkOutput("out_last_idle", 32'(out_last), 32'(0));
    end
    if (expQ.size() > 0 && rdy) begin
      b = expQ.pop_front();
      if (b.last) modelFrames = modelFrames + 16'd1;
    end
    if (fw) begin
      if (expQ.size() == 0) pushFrame(res);
      else modelOvf = 1'b1;
    end
    @(posedge clk_in);
    #1;
    cycleNo++;
    fifo_write = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk_in);
    rst        = 1'b1;
    fifo_write = 1'b0;
    out_ready  = 1'b0;
    result     = '0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_last", 32'(out_last), 32'(0));
    checkOutput("rst_out_data", out_data, 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_overflow", 32'(overflow), 32'(0));
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    expQ.delete();
    modelOvf    = 1'b0;
    modelFrames = '0;
    cycleNo     = 0;
  endtask

  function automatic logic readyFor(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 4 == 0) || (n % 4 == 3);
      default: return ($urandom_range(3, 0) != 0);
    endcase
  endfunction

  // Drain the model queue with a given ready pattern, bounded in cycles.
  task automatic drain(input int mode, input int budget);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      applyStimulus(1'b0, '0, readyFor(mode, n));
      n++;
    end
    checkOutput("drain_timeout", 32'(expQ.size()), 32'(0));
  endtask

  task automatic runScenario(input scen_t s);
    logic [IN_W-1:0] second;
    logic            sent2;
    logic            rdy;
    logic            fw;
    int              n;
    $display("[TB] scenario %s", s.name);
    doReset();
    second = (s.strobe2At == -2) ? makePattern(3) : makePattern(2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, makePattern(s.pattern), readyFor(s.readyMode, 0));
    sent2 = (s.strobe2At == -1);
    n = 1;
    while ((expQ.size() > 0 || !sent2) && n < 2000) begin
      rdy = readyFor(s.readyMode, n);
      fw  = 1'b0;
      if (!sent2 && s.strobe2At >= 0 && (BEATS - expQ.size()) == s.strobe2At) fw = 1'b1;
      if (!sent2 && s.strobe2At == -2 && expQ.size() == 1 && rdy) fw = 1'b1;
      if (fw) sent2 = 1'b1;
      applyStimulus(fw, fw ? second : '0, rdy);
      n++;
    end
    checkOutput({s.name, "_timeout"}, 32'(expQ.size()), 32'(0));
    checkOutput({s.name, "_frame_cnt"}, 32'(frame_cnt), 32'(s.expFrames));
    checkOutput({s.name, "_overflow"}, 32'(overflow), 32'(s.expOvf));
  endtask

  initial begin
    modelOvf    = 1'b0;
    modelFrames = '0;
    cycleNo     = 0;

    scens[0] = '{name: "basic",        pattern: 0, readyMode: 0, strobe2At: -1, expFrames: 16'd1, expOvf: 1'b0};
    scens[1] = '{name: "backpressure", pattern: 0, readyMode: 1, strobe2At: -1, expFrames: 16'd1, expOvf: 1'b0};
    scens[2] = '{name: "overflow",     pattern: 0, readyMode: 0, strobe2At: 40, expFrames: 16'd1, expOvf: 1'b1};
    scens[3] = '{name: "back2back",    pattern: 0, readyMode: 0, strobe2At: -2, expFrames: 16'd2, expOvf: 1'b0};
    scens[4] = '{name: "checksum",     pattern: 1, readyMode: 1, strobe2At: -1, expFrames: 16'd1, expOvf: 1'b0};

    for (int s = 0; s < 5; s++) runScenario(scens[s]);

    // Reset in the middle of a second frame abandons it and clears the count.
    $display("[TB] scenario reset_mid_frame");
    doReset();
    applyStimulus(1'b1, makePattern(0), 1'b1);
    drain(0, 500);
    applyStimulus(1'b1, makePattern(3), 1'b1);
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_frame_cnt_before", 32'(frame_cnt), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_out_valid", 32'(out_valid), 32'(0));
    checkOutput("mid_out_data", out_data, 32'(0));
    checkOutput("mid_out_last", 32'(out_last), 32'(0));
    checkOutput("mid_busy", 32'(busy), 32'(0));
    checkOutput("mid_frame_cnt", 32'(frame_cnt), 32'(0));
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    expQ.delete();
    modelOvf    = 1'b0;
    modelFrames = '0;
    applyStimulus(1'b1, makePattern(0), 1'b1);
    drain(0, 500);
    checkOutput("post_reset_frame_cnt", 32'(frame_cnt), 32'(1));

    // Randomized strobes, data and backpressure against the model.
    $display("[TB] scenario random");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      logic fwr;
      fwr = ($urandom_range(39, 0) == 0);
      applyStimulus(fwr, fwr ? makePattern(3) : '0, ($urandom_range(3, 0) != 0));
    end
    drain(2, 2000);
    checkOutput("random_frame_cnt", 32'(frame_cnt), 32'(modelFrames));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Downstream stage of the Toeplitz result generator. Captures each 3072-bit hash result on the generator's `fifo_write` strobe and streams it out as 32-bit words over a valid/ready interface, LSW first, toward the host/output link. It provides a single capture buffer, frame counting and overflow detection, so the wide result bus never crosses the chip boundary.

## Interface
- `IN_W`, default 3072: result width. Must be a multiple of `OUT_W`.
- `OUT_W`, default 32: output word width.
- `NWORDS`: derived, `IN_W/OUT_W` (96 at defaults).
- `clk_in`  in  1: the single clock. One clock; reset is asynchronous and active-high.
- `rst`  in  1: asynchronous, active-high reset.
- `result`  in  IN_W: result vector from the generator, valid while `fifo_write`=1.
- `fifo_write`  in  1: one-cycle capture strobe.
- `out_data`  out  OUT_W: current output word.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: sink accepts a word.
- `out_last`  out  1: marks the final beat of a frame.
- `busy`  out  1: a frame is held or being sent.
- `overflow`  out  1: sticky; a strobe arrived while busy and was dropped.
- `frame_cnt`  out  16: number of frames fully sent, wraps at 65535→0.

## Operation
- States: IDLE, SEND, and CHK (CHK only with the macro).
- IDLE: `fifo_write`=1 → latch `result` into `buf`, `idx`←0, go to SEND.
- SEND: `out_data`=`buf[idx*OUT_W +: OUT_W]` and `out_valid`=1. A handshake (`out_valid`&`out_ready`) advances `idx` by 1.
- Handshake on `idx`=NWORDS-1: go to CHK (macro on), otherwise go to IDLE and increment `frame_cnt`.
- CHK: `out_data`=checksum and `out_last`=1. A handshake goes to IDLE and increments `frame_cnt`.
- `out_last` is high only on the final beat of a frame: word NWORDS-1 without the macro, the checksum beat with it.
- `busy` = (state != IDLE).
- Word order: word 0 = `result[OUT_W-1:0]`, sent first.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `overflow`=0, `frame_cnt`=0, state=IDLE, `idx`=0, `buf`=0.
- Latency: `fifo_write` sampled at edge N → `out_valid`=1 with word 0 in cycle N+1.
- Throughput: one word per cycle while `out_ready`=1.
- Valid/ready rules: once `out_valid` is asserted, `out_valid` and `out_data` stay stable until a handshake. `out_valid` never depends combinationally on `out_ready`.
- Back-to-back capture: `fifo_write` in the same cycle as the frame's final handshake is captured. There is no overflow, `frame_cnt` increments, and `out_valid` stays 1 with the new word 0 in the next cycle.
- Dropped strobe: `fifo_write` while busy at any other time is dropped. `buf` is unchanged and `overflow`←1, cleared only by `rst`.
- Reset mid-frame: the frame is abandoned. All outputs go to their reset values asynchronously and the frame is not counted.
- `frame_cnt` wraps modulo 2^16 and has no saturation.

## Configuration
- `RESULT_SER_CHECKSUM_EN` defined:
  - An XOR accumulator clears on capture and XORs each word at its handshake.
  - One extra beat (CHK) carries the XOR of all NWORDS words.
  - A frame is NWORDS+1 beats.
- Not defined: no CHK state and no accumulator. A frame is NWORDS beats, and `out_last` is on word NWORDS-1.

## Structure
- Package `result_ser_pkg`:
  - state enum (IDLE/SEND/CHK);
  - defaults `RES_IN_W`=3072 and `RES_OUT_W`=32;
  - `RES_NWORDS`;
  - `IDX_W`=$clog2(NWORDS+1).
- One natural sub-module, `result_xor_acc`: an OUT_W XOR accumulator with clear/enable ports, instantiated only under `RESULT_SER_CHECKSUM_EN`.
- Top level: capture register, word mux, FSM and counters.

## Test plan
- **Basic frame:** `result` word i = i, `out_ready`=1, strobe at cycle 10.
  - `out_data` = 0,1,…,95 in cycles 11–106.
  - `out_last` in cycle 106 (macro off); `frame_cnt`=1.
  - Macro on: checksum 0x00000000 with `out_last` in cycle 107.
- **Backpressure:** as above, with `out_ready` toggling 1,0,0,1.
  - Words are never skipped or duplicated.
  - `out_data` is stable while `out_ready`=0.
- **Overflow:** strobe, then a second strobe (all-ones `result`) at word 40.
  - The frame completes with the original data; `overflow`=1 and `frame_cnt`=1.
- **Back-to-back:** second strobe on the final-handshake cycle.
  - No gap in `out_valid`; the second frame's word 0 follows immediately.
  - `overflow`=0 and `frame_cnt`=2.
- **Checksum (macro on):** only word 5 = 0xA5A5A5A5, others 0 → checksum beat = 0xA5A5A5A5.
- **Reset mid-frame:** assert `rst` at word 50.
  - Outputs are 0 immediately and `frame_cnt`=0.
  - A new strobe after release streams a full frame from word 0.
